// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per keyexp_start, S-box shared byte-serially.
// Optional round-key store enabled by defining KEYEXP_STORE_EN (adds rk_idx/rk_out).
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             keyexp_start,
  output logic             keyexp_finished,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_num,
  output logic             busy,
  output logic [7:0]       sbox_addr,
  input  logic [7:0]       sbox_data
`ifdef KEYEXP_STORE_EN
  ,
  input  logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out
`endif
);

  typedef enum logic [1:0] {IDLE, SUB, XOR, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] temp;
  logic [31:0] sub;
  logic [1:0]  idx;
  logic [7:0]  rcon;
  logic        can_step;
  logic        load_fire;
  logic        start_fire;
  logic [31:0] w3_rot;
  logic [31:0] nw0, nw1, nw2, nw3;
  logic [7:0]  rcon_nxt;

  assign can_step   = (round_num < 4'(NUM_ROUNDS));
  assign load_fire  = (state == IDLE) && key_load;
  assign start_fire = (state == IDLE) && !key_load && keyexp_start;
  assign w3_rot     = {round_key[23:0], round_key[31:24]};

  assign nw0      = round_key[127:96] ^ sub ^ {rcon, 24'h0};
  assign nw1      = round_key[95:64] ^ nw0;
  assign nw2      = round_key[63:32] ^ nw1;
  assign nw3      = round_key[31:0]  ^ nw2;
  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  assign keyexp_finished = (state == DONE);
  assign busy            = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_fire) state_nxt = can_step ? SUB : DONE;
      SUB:  if (idx == 2'd3) state_nxt = XOR;
      XOR:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // temp shifts left so its next byte is always temp[23:16]; sub fills MSB byte first.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      round_key <= '0;
      round_num <= '0;
      rcon      <= 8'h01;
      temp      <= '0;
      sub       <= '0;
      idx       <= '0;
      sbox_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_fire) begin
            round_key <= key_in;
            round_num <= '0;
            rcon      <= 8'h01;
          end else if (start_fire && can_step) begin
            temp      <= w3_rot;
            idx       <= '0;
            sbox_addr <= w3_rot[31:24];
          end
        end
        SUB: begin
          sub  <= {sub[23:0], sbox_data};
          temp <= {temp[23:0], 8'h00};
          idx  <= idx + 2'd1;
          if (idx != 2'd3) sbox_addr <= temp[23:16];
        end
        XOR: begin
          round_key <= {nw0, nw1, nw2, nw3};
          round_num <= round_num + 4'd1;
          rcon      <= rcon_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef KEYEXP_STORE_EN
  logic [KEY_W-1:0]  rk_mem [0:NUM_ROUNDS];
  logic [NUM_ROUNDS:0] rk_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rk_valid <= '0;
    end else if (load_fire) begin
      rk_valid <= {{NUM_ROUNDS{1'b0}}, 1'b1};
    end else if (state == XOR) begin
      rk_valid[round_num + 4'd1] <= 1'b1;
    end
  end

  // NOTE: the key array itself is not reset; the valid flags alone gate what rk_out can expose.
  always_ff @(posedge clk) begin
    if (load_fire)          rk_mem[0] <= key_in;
    else if (state == XOR)  rk_mem[round_num + 4'd1] <= {nw0, nw1, nw2, nw3};
  end

  always_comb begin
    rk_out = '0;
    if ((rk_idx <= 4'(NUM_ROUNDS)) && rk_valid[rk_idx]) rk_out = rk_mem[rk_idx];
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: arithmetic S-box and FIPS-197 style key-schedule model.
// Exercises the round-key store too when KEYEXP_STORE_EN is defined.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         keyexp_start;
  logic         keyexp_finished;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         busy;
  logic [7:0]   sbox_addr;
  logic [7:0]   sbox_data;
`ifdef KEYEXP_STORE_EN
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [7:0]   sbox_tbl [256];
  logic [127:0] exp_rk   [11];
  logic [7:0]   seen     [4];
  int           lat;

  always #5 clk = ~clk;
  assign sbox_data = sbox_tbl[sbox_addr];

  aes_key_expand dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .key_load        (key_load),
    .key_in          (key_in),
    .keyexp_start    (keyexp_start),
    .keyexp_finished (keyexp_finished),
    .round_key       (round_key),
    .round_num       (round_num),
    .busy            (busy),
    .sbox_addr       (sbox_addr),
    .sbox_data       (sbox_data)
`ifdef KEYEXP_STORE_EN
    ,
    .rk_idx          (rk_idx),
    .rk_out          (rk_out)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      r = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_tbl[a] = s ^ 8'h63;
    end
  endtask

  task automatic compute_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Pulses start, then waits (bounded) for keyexp_finished; lat counts edges after the start edge.
  task automatic do_start();
    keyexp_start = 1'b1;
    tick();
    keyexp_start = 1'b0;
    lat = 0;
    while (keyexp_finished !== 1'b1 && lat < 20) begin
      if (lat < 4) seen[lat] = sbox_addr;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; key_load = 1'b0; keyexp_start = 1'b0; key_in = '0;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    n_checks++; if (round_key !== 128'h0) begin n_fail++; $display("FAIL reset_round_key got %h exp 0", round_key); end
    n_checks++; if (round_num !== 4'd0) begin n_fail++; $display("FAIL reset_round_num got %0d exp 0", round_num); end
    n_checks++; if (busy !== 1'b0 || keyexp_finished !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got busy=%b fin=%b exp 0/0", busy, keyexp_finished); end
    n_checks++; if (sbox_addr !== 8'h00) begin n_fail++; $display("FAIL reset_sbox_addr got %h exp 00", sbox_addr); end
  endtask

  task automatic test_fips_vector();
    compute_schedule(FIPS_KEY);
    load_key(FIPS_KEY);
    n_checks++; if (round_key !== FIPS_KEY) begin n_fail++; $display("FAIL load_round_key got %h exp %h", round_key, FIPS_KEY); end
    n_checks++; if (round_num !== 4'd0 || busy !== 1'b0 || keyexp_finished !== 1'b0) begin
      n_fail++; $display("FAIL load_status got num=%0d busy=%b fin=%b exp 0/0/0", round_num, busy, keyexp_finished); end
    do_start();
    n_checks++; if ({seen[0], seen[1], seen[2], seen[3]} !== 32'hcf4f3c09) begin
      n_fail++; $display("FAIL sbox_addr_seq got %h %h %h %h exp cf 4f 3c 09", seen[0], seen[1], seen[2], seen[3]); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL round1_latency got %0d exp 5", lat); end
    n_checks++; if (round_key !== FIPS_R1) begin n_fail++; $display("FAIL round1_key got %h exp %h", round_key, FIPS_R1); end
    n_checks++; if (round_num !== 4'd1) begin n_fail++; $display("FAIL round1_num got %0d exp 1", round_num); end
    tick();
    n_checks++; if (keyexp_finished !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL finished_pulse_width got fin=%b busy=%b exp 0/0", keyexp_finished, busy); end
    for (int r = 2; r <= 10; r++) begin
      do_start();
      n_checks++; if (round_key !== exp_rk[r] || round_num !== 4'(r) || lat !== 5) begin
        n_fail++; $display("FAIL round%0d got key=%h num=%0d lat=%0d exp key=%h num=%0d lat=5",
                           r, round_key, round_num, lat, exp_rk[r], r); end
      tick();
    end
    n_checks++; if (round_key !== FIPS_R10) begin n_fail++; $display("FAIL round10_key got %h exp %h", round_key, FIPS_R10); end
    do_start();
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL refused_latency got %0d exp 0", lat); end
    n_checks++; if (round_key !== FIPS_R10 || round_num !== 4'd10) begin
      n_fail++; $display("FAIL refused_unchanged got key=%h num=%0d exp %h/10", round_key, round_num, FIPS_R10); end
    tick();
    n_checks++; if (busy !== 1'b0 || keyexp_finished !== 1'b0) begin
      n_fail++; $display("FAIL refused_return_idle got busy=%b fin=%b exp 0/0", busy, keyexp_finished); end
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      compute_schedule(k);
      load_key(k);
      for (int r = 1; r <= 10; r++) begin
        do_start();
        n_checks++; if (round_key !== exp_rk[r] || round_num !== 4'(r)) begin
          n_fail++; $display("FAIL rand_key%0d_round%0d got %h num=%0d exp %h", n, r, round_key, round_num, exp_rk[r]); end
        tick();
      end
    end
  endtask

  task automatic test_collision();
    logic [127:0] k;
    int pulses;
    k = {$urandom, $urandom, $urandom, $urandom};
    key_in = k; key_load = 1'b1; keyexp_start = 1'b1;
    tick();
    key_load = 1'b0; keyexp_start = 1'b0;
    n_checks++; if (round_key !== k || round_num !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL collision_load got key=%h num=%0d busy=%b exp %h/0/0", round_key, round_num, busy, k); end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (keyexp_finished === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (pulses !== 0 || round_num !== 4'd0) begin
      n_fail++; $display("FAIL collision_no_pulse got pulses=%0d num=%0d exp 0/0", pulses, round_num); end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] k;
    int pulses;
    k = {$urandom, $urandom, $urandom, $urandom};
    compute_schedule(k);
    load_key(k);
    keyexp_start = 1'b1;
    tick();
    keyexp_start = 1'b0;
    tick();
    keyexp_start = 1'b1; key_load = 1'b1; key_in = ~k;
    tick();
    keyexp_start = 1'b0; key_load = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (keyexp_finished === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_ignore_pulses got %0d exp 1", pulses); end
    n_checks++; if (round_key !== exp_rk[1] || round_num !== 4'd1) begin
      n_fail++; $display("FAIL busy_ignore_key got %h num=%0d exp %h/1", round_key, round_num, exp_rk[1]); end
  endtask

  task automatic test_reset_mid();
    load_key({$urandom, $urandom, $urandom, $urandom});
    keyexp_start = 1'b1;
    tick();
    keyexp_start = 1'b0;
    tick();
    #1 n_rst = 1'b0;
    #1;
    n_checks++; if (round_key !== 128'h0 || round_num !== 4'd0 || sbox_addr !== 8'h00) begin
      n_fail++; $display("FAIL midreset_data got key=%h num=%0d addr=%h exp 0/0/0", round_key, round_num, sbox_addr); end
    n_checks++; if (busy !== 1'b0 || keyexp_finished !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags got busy=%b fin=%b exp 0/0", busy, keyexp_finished); end
    #1 n_rst = 1'b1;
    repeat (8) tick();
    n_checks++; if (busy !== 1'b0 || round_key !== 128'h0) begin
      n_fail++; $display("FAIL midreset_discard got busy=%b key=%h exp 0/0", busy, round_key); end
  endtask

`ifdef KEYEXP_STORE_EN
  task automatic test_store();
    logic [127:0] k;
    compute_schedule(FIPS_KEY);
    load_key(FIPS_KEY);
    for (int r = 1; r <= 10; r++) begin do_start(); tick(); end
    rk_idx = 4'd1; #1;
    n_checks++; if (rk_out !== FIPS_R1) begin n_fail++; $display("FAIL store_idx1 got %h exp %h", rk_out, FIPS_R1); end
    rk_idx = 4'd0; #1;
    n_checks++; if (rk_out !== FIPS_KEY) begin n_fail++; $display("FAIL store_idx0 got %h exp %h", rk_out, FIPS_KEY); end
    rk_idx = 4'd10; #1;
    n_checks++; if (rk_out !== exp_rk[10]) begin n_fail++; $display("FAIL store_idx10 got %h exp %h", rk_out, exp_rk[10]); end
    rk_idx = 4'd11; #1;
    n_checks++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL store_idx11 got %h exp 0", rk_out); end
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    rk_idx = 4'd5; #1;
    n_checks++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL store_cleared got %h exp 0", rk_out); end
    rk_idx = 4'd0; #1;
    n_checks++; if (rk_out !== k) begin n_fail++; $display("FAIL store_new_key got %h exp %h", rk_out, k); end
  endtask
`endif

  initial begin
`ifdef KEYEXP_STORE_EN
    rk_idx = 4'd0;
`endif
    build_sbox();
    test_reset();
    test_fips_vector();
    test_random_keys();
    test_collision();
    test_busy_ignore();
    test_reset_mid();
`ifdef KEYEXP_STORE_EN
    test_store();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES-128 key-schedule stage, directly upstream of the AES round datapath. It is driven by the AHB-side controller through the keyexp_start/keyexp_finished handshake used in its KEYEX state. Each start request produces the next round key from the current one. S-box lookups go through a single shared byte-wide S-box port, one byte per cycle, so no S-box table is duplicated here.

Parameters:
NUM_ROUNDS, 10, last round index; keyexp_start is refused once round_num reaches this value
KEY_W, 128, key/round-key width; fixed at 128, not a general-width parameter

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
key_load  input  1  one-cycle pulse; latch key_in as round-0 key
key_in  input  128  cipher key, word 0 in bits [127:96]
keyexp_start  input  1  one-cycle pulse; compute next round key
keyexp_finished  output  1  one-cycle pulse; round_key/round_num valid
round_key  output  128  current round key, registered
round_num  output  4  index of the key currently held in round_key (0..10)
busy  output  1  high in every state except IDLE
sbox_addr  output  8  byte presented to the shared S-box
sbox_data  input  8  combinational S-box result for sbox_addr, same cycle

Behaviour:
- Reset values: round_key=0, round_num=0, rcon=8'h01, keyexp_finished=0, busy=0, sbox_addr=0, state=IDLE. Reset is honoured mid-operation; a partial round is discarded.
- FSM states: IDLE, SUB, XOR, DONE.
- IDLE + key_load: round_key<=key_in, round_num<=0, rcon<=8'h01. If key_load and keyexp_start are both high, key_load wins and start is dropped.
- IDLE + keyexp_start with round_num<NUM_ROUNDS: capture temp = RotWord(w3) = {w3[23:0],w3[31:24]}, byte index i=0, go to SUB.
- IDLE + keyexp_start with round_num==NUM_ROUNDS: go to DONE directly. The pulse still happens; round_key and round_num are unchanged.
- SUB, 4 cycles, i=0..3: sbox_addr = temp byte i, MSB byte first. sub[31-8i -: 8] <= sbox_data. After i==3, go to XOR.
- XOR, 1 cycle: w0'=w0^sub^{rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'. round_key<=new words, round_num<=round_num+1, rcon<=xtime(rcon): shift left; if bit7 was set, result ^8'h1b (8'h80 -> 8'h1b, 8'h1b -> 8'h36). Go to DONE.
- DONE, 1 cycle: keyexp_finished=1, then go to IDLE.
- Latency: keyexp_start sampled at edge N gives keyexp_finished high during cycle N+6, with round_key already updated. A refused start pulses during cycle N+1.
- key_load and keyexp_start received while busy are ignored; they are not queued.
- sbox_addr holds its last value outside SUB. The shared S-box owner may read it only while busy.

Optional Feature:
KEYEXP_STORE_EN
- Defined: adds a 11x128 register file, written with key_in on key_load and with each new round key in XOR. Also adds ports rk_idx (input 4) and rk_out (output 128). rk_out = stored key[rk_idx], combinational; returns 0 for rk_idx>10 or for entries not yet written since reset/key_load. key_load clears the valid flags of entries 1..10.
- Undefined: no storage and no rk_idx/rk_out ports; only the current round_key is available.

Test Plan:
- Reset, then key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c -> round_key equals key_in, round_num=0, busy=0, keyexp_finished=0. Bench supplies a behavioural S-box.
- One keyexp_start -> sbox_addr sequence cf,4f,3c,09. keyexp_finished pulses exactly 6 cycles after start. round_key=a0fafe1788542cb123a339392a6c7605, round_num=1.
- Ten consecutive starts -> round 10 key d014f9a8c9ee2589e13f0cc8b6630ca6. rcon progresses 01,02,04,08,10,20,40,80,1b,36.
- Eleventh start -> keyexp_finished pulses the next cycle; round_key and round_num=10 unchanged.
- Simultaneous key_load+keyexp_start in IDLE -> key loaded, no pulse. keyexp_start during SUB is ignored. n_rst low during SUB -> all outputs return to reset values immediately.
- With KEYEXP_STORE_EN: after 10 rounds, rk_idx=1 -> a0fafe17...7605 and rk_idx=0 -> original key. After a new key_load, rk_idx=5 -> 0.
